// File: rtl/regfile_ctrl_pkg.sv
// rtl/regfile_ctrl_pkg.sv - shared opcodes, FSM states and strobe-bundle bit indices
package regfile_ctrl_pkg;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_LDA   = 4'h1;
    localparam logic [3:0] OP_LDB   = 4'h2;
    localparam logic [3:0] OP_MOVAB = 4'h3;
    localparam logic [3:0] OP_MOVBA = 4'h4;
    localparam logic [3:0] OP_ADD   = 4'h5;
    localparam logic [3:0] OP_SUB   = 4'h6;
    localparam logic [3:0] OP_OUTA  = 4'h7;
    localparam logic [3:0] OP_OUTB  = 4'h8;
    localparam logic [3:0] OP_CLRA  = 4'h9;
    localparam logic [3:0] OP_CLRB  = 4'hA;
    localparam logic [3:0] OP_HALT  = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DECODE = 3'd1,
        ST_EX1    = 3'd2,
        ST_EX2    = 3'd3,
        ST_HALT   = 3'd4
    } state_t;

    // Bit positions inside the strobe bundle driven towards the datapath
    localparam int STB_RS1     = 0;
    localparam int STB_RS2     = 1;
    localparam int STB_WS1     = 2;
    localparam int STB_RS3     = 3;
    localparam int STB_RS4     = 4;
    localparam int STB_WS2     = 5;
    localparam int STB_ALU_OE  = 6;
    localparam int STB_ALU_SUB = 7;
    localparam int STB_OUT_LD  = 8;
    localparam int STB_LRST_A  = 9;
    localparam int STB_LRST_B  = 10;
    localparam int STB_W       = 11;

    typedef logic [STB_W-1:0] strobe_t;

endpackage

// File: rtl/regfile_seq_ctrl_if.sv
// rtl/regfile_seq_ctrl_if.sv - instruction valid/ready handshake bundle
interface regfile_seq_ctrl_if #(
    parameter int IW = 8
);
    logic [IW-1:0] instr;
    logic          instr_valid;
    logic          instr_ready;

    modport master (output instr, output instr_valid, input  instr_ready);
    modport slave  (input  instr, input  instr_valid, output instr_ready);
endinterface

// File: rtl/regfile_op_decode.sv
// rtl/regfile_op_decode.sv - opcode + phase to strobe vector, illegal and two-phase flags
module regfile_op_decode
    import regfile_ctrl_pkg::*;
#(
    parameter int OPW = 4
) (
    input  logic [OPW-1:0] i_op,
    input  logic           i_phase2,
    output strobe_t        o_strobe,
    output logic           o_illegal,
    output logic           o_two_phase
);

    always_comb begin
        o_strobe    = '0;
        o_illegal   = 1'b0;
        o_two_phase = (i_op == OP_ADD) || (i_op == OP_SUB);
        if (i_phase2) begin
            // second ALU phase: result goes back into A from the bus
            if (o_two_phase) begin
                o_strobe[STB_ALU_OE]  = 1'b1;
                o_strobe[STB_RS2]     = 1'b1;
                o_strobe[STB_ALU_SUB] = (i_op == OP_SUB);
            end
        end else begin
            case (i_op)
                OP_NOP:   ;
                OP_LDA:   o_strobe[STB_RS1] = 1'b1;
                OP_LDB:   o_strobe[STB_RS3] = 1'b1;
                OP_MOVAB: begin
                    o_strobe[STB_WS1] = 1'b1;
                    o_strobe[STB_RS4] = 1'b1;
                end
                OP_MOVBA: begin
                    o_strobe[STB_WS2] = 1'b1;
                    o_strobe[STB_RS2] = 1'b1;
                end
                OP_ADD:   o_strobe[STB_ALU_OE] = 1'b1;
                OP_SUB: begin
                    o_strobe[STB_ALU_OE]  = 1'b1;
                    o_strobe[STB_ALU_SUB] = 1'b1;
                end
                OP_OUTA: begin
                    o_strobe[STB_WS1]    = 1'b1;
                    o_strobe[STB_OUT_LD] = 1'b1;
                end
                OP_OUTB: begin
                    o_strobe[STB_WS2]    = 1'b1;
                    o_strobe[STB_OUT_LD] = 1'b1;
                end
                OP_CLRA:  o_strobe[STB_LRST_A] = 1'b1;
                OP_CLRB:  o_strobe[STB_LRST_B] = 1'b1;
                OP_HALT:  ;
                default:  o_illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/regfile_seq_ctrl.sv
// rtl/regfile_seq_ctrl.sv - one-instruction-at-a-time sequencer for register file and ALU bus strobes
module regfile_seq_ctrl
    import regfile_ctrl_pkg::*;
#(
    parameter int OPW  = 4,
    parameter int DW   = 4,
    parameter int CNTW = 8
) (
    input  logic                clk,
    input  logic                grst,
    regfile_seq_ctrl_if.slave   bus,
    input  logic                resume,
    output logic [DW-1:0]       imm,
    output logic                rs1,
    output logic                rs2,
    output logic                ws1,
    output logic                rs3,
    output logic                rs4,
    output logic                ws2,
    output logic                alu_oe,
    output logic                alu_sub,
    output logic                out_ld,
    output logic                lrst_a,
    output logic                lrst_b,
    output logic                busy,
    output logic                halted,
    output logic                illegal,
    output logic [CNTW-1:0]     retired
);

    state_t          r_state;
    logic [OPW-1:0]  r_op;
    logic [DW-1:0]   r_imm;
    strobe_t         r_stb;
    logic            r_illegal;
    logic            r_busy;
    logic            r_halted;
    logic [CNTW-1:0] r_retired;

    strobe_t w_stb;
    logic    w_illegal;
    logic    w_two_phase;

    // Decode looks one state ahead so strobes can be registered on entry to EX1/EX2
    regfile_op_decode #(.OPW(OPW)) u_decode (
        .i_op        (r_op),
        .i_phase2    (r_state == ST_EX1),
        .o_strobe    (w_stb),
        .o_illegal   (w_illegal),
        .o_two_phase (w_two_phase)
    );

    always_ff @(posedge clk or posedge grst) begin
        if (grst) begin
            r_state   <= ST_IDLE;
            r_op      <= '0;
            r_imm     <= '0;
            r_stb     <= '0;
            r_illegal <= 1'b0;
            r_busy    <= 1'b0;
            r_halted  <= 1'b0;
            r_retired <= '0;
        end else begin
            r_stb     <= '0;
            r_illegal <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.instr_valid) begin
                        r_op    <= bus.instr[OPW+DW-1:DW];
                        r_imm   <= bus.instr[DW-1:0];
                        r_busy  <= 1'b1;
                        r_state <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    if (r_op == OP_HALT) begin
                        r_busy    <= 1'b0;
                        r_halted  <= 1'b1;
                        r_retired <= r_retired + CNTW'(1);
                        r_state   <= ST_HALT;
                    end else begin
                        r_stb     <= w_stb;
                        r_illegal <= w_illegal;
                        r_state   <= ST_EX1;
                    end
                end
                ST_EX1: begin
                    if (w_two_phase) begin
                        r_stb   <= w_stb;
                        r_state <= ST_EX2;
                    end else begin
                        r_busy    <= 1'b0;
                        r_retired <= r_retired + CNTW'(1);
                        r_state   <= ST_IDLE;
                    end
                end
                ST_EX2: begin
                    r_busy    <= 1'b0;
                    r_retired <= r_retired + CNTW'(1);
                    r_state   <= ST_IDLE;
                end
                ST_HALT: begin
                    if (resume) begin
                        r_halted <= 1'b0;
                        r_state  <= ST_IDLE;
                    end
                end
                default: begin
                    r_busy   <= 1'b0;
                    r_halted <= 1'b0;
                    r_state  <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.instr_ready = (r_state == ST_IDLE);

    assign imm     = r_imm;
    assign rs1     = r_stb[STB_RS1];
    assign rs2     = r_stb[STB_RS2];
    assign ws1     = r_stb[STB_WS1];
    assign rs3     = r_stb[STB_RS3];
    assign rs4     = r_stb[STB_RS4];
    assign ws2     = r_stb[STB_WS2];
    assign alu_oe  = r_stb[STB_ALU_OE];
    assign alu_sub = r_stb[STB_ALU_SUB];
    assign out_ld  = r_stb[STB_OUT_LD];
    assign lrst_a  = r_stb[STB_LRST_A];
    assign lrst_b  = r_stb[STB_LRST_B];
    assign busy    = r_busy;
    assign halted  = r_halted;
    assign illegal = r_illegal;
    assign retired = r_retired;

endmodule
